dce_uart_rx: RTL and testbench
==============================

# dce_uart_rx

DCE-side UART receiver that deserialises 8N1 characters sent by the UART transactor on its `txd` line. It buffers received bytes in a small FIFO and throttles the sender through `cts` hardware flow control. It sits inside the DCE, in place of the receive half of the loopback, with the same per-bit clock divisor `DBR` that the transactor uses.

## Interface
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, at least 4.
- `CTS_MARGIN`, 2: free entries required to keep `cts` asserted.
- `clock` in 1: single clock for all logic; rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `txd` in 1: serial data from the DTE; idle high; asynchronous to `clock`.
- `dbr` in 32: clocks per bit period; sampled at start-bit detection.
- `cts` out 1: clear-to-send to the DTE; 1 means the DTE may start a character.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid` is high.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts the head byte when `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun_err` out 1: one-cycle pulse when a good character arrives while the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input sync:** `txd` passes through a 2-flop synchroniser, with reset value 1. All logic below uses the synchronised signal `rxs`.
- **Divisor:** `bitlen` = max(`dbr`, 4) is latched on start detection. `half` = `bitlen`>>1. A mid-character change of `dbr` has no effect until the next start bit.
- **FSM states:**
  - IDLE:
    - `rxs`=0 → load counter with `half`-1 → START.
  - START:
    - At counter 0, sample `rxs`.
    - Sample 1 → IDLE (glitch rejected, nothing pushed).
    - Sample 0 → load `bitlen`-1 and set bit index 0 → DATA.
  - DATA:
    - At each counter 0, shift `rxs` into the shift register LSB first and reload `bitlen`-1.
    - After bit 7 → STOP.
  - STOP:
    - At counter 0, sample `rxs`.
    - Sample 1 with FIFO not full → push the byte → IDLE.
    - Sample 1 with FIFO full and no pop this cycle → pulse `overrun_err`, drop the byte → IDLE.
    - Sample 0 → pulse `frame_err`, discard the byte → BREAK.
  - BREAK:
    - Wait for `rxs`=1 → IDLE. This prevents a held-low line from being read as repeated characters.
- **FIFO:**
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits; pointers wrap modulo the depth.
  - `rx_data` is driven from the head entry, with no extra register stage.
  - Push and pop in the same cycle: allowed at any occupancy, including full. `fifo_count` is unchanged and the push is accepted.
  - Pop while empty is ignored.
- **Flow control:**
  - `cts` is registered: `cts` <= (`fifo_count_next` <= `FIFO_DEPTH`-`CTS_MARGIN`).
  - The margin absorbs one character already in flight when `cts` falls.
  - `cts` has no effect on a character already in progress; it is only guidance to the DTE.
- **Reset (assertion at any time, including mid-character):**
  - FSM → IDLE; pointers and count → 0; synchroniser → 1.
  - Outputs: `cts`=0, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun_err`=0, `fifo_count`=0.
  - A partial character is discarded.
  - `cts` rises on the first clock after `reset_n` deasserts.

## Timing
- Synchroniser latency: 2 clocks from a `txd` edge to `rxs`.
- Sampling instants, counted from the cycle the falling edge of `rxs` is seen:
  - Start bit: `half` clocks later.
  - Data bit k: `half`+(k+1)·`bitlen`.
  - Stop bit: `half`+9·`bitlen`.
- Push happens at the stop-sample clock edge. `rx_valid` rises the following cycle.
  - Total latency from the `txd` falling edge to `rx_valid` ≈ 3+`half`+9·`bitlen` clocks, ±1.
- IDLE is re-entered in the cycle after the stop sample. A back-to-back start bit arriving half a bit later is therefore caught.
- Error pulses are asserted for exactly the cycle after the stop sample, together with the corresponding FIFO update.
- `fifo_count` and `rx_valid` update on the cycle after a push or pop.

## Test plan
- **Single byte:** `dbr`=16, DTE sends 0x55 → `rx_valid` rises about 155 clocks after the start edge with `rx_data`=0x55 and `fifo_count`=1. Holding `rx_ready`=1 for one cycle → `rx_valid`=0.
- **Back-to-back, no backpressure:** `dbr`=10, 20 random bytes sent back-to-back, `rx_ready`=1 throughout → all 20 bytes received in order with no error pulses.
- **Flow control and overrun:** `dbr`=16, `rx_ready`=0.
  - `cts` falls when `fifo_count` reaches 7.
  - The 8th byte is stored.
  - Sending a 9th byte anyway → `overrun_err` pulses once, `fifo_count` stays 8, and the head byte is still the first byte.
- **Framing and break:**
  - 0xA3 with the stop bit forced low → `frame_err` pulses and nothing is pushed.
  - Line held low for 40 bit times → no further pulses.
  - After the line returns high, the next byte 0x0F is received correctly.
- **Glitch and mid-character reset:**
  - A low pulse of `half`-2 clocks on `txd` → no push, FSM back to IDLE.
  - `reset_n` low during data bit 4 → outputs take their reset values.
  - Next byte 0xC3 is received correctly.
- **Full push/pop:** FIFO full and `rx_ready`=1 in the same cycle as a stop sample → no `overrun_err`, count stays 8, and the new byte appears at the tail in order.

Source files
------------

// File: rtl/dce_uart_rx.sv
// DCE-side 8N1 UART receiver with a small receive FIFO and cts flow control.
// Start, data and stop bits are sampled mid-bit using a divisor latched when the start bit is detected.
module dce_uart_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int CTS_MARGIN = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          txd,
    input  logic [31:0]                   dbr,
    output logic                          cts,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic           r_sync1;
    logic           r_rxs;
    state_t         r_state;
    logic [31:0]    r_cnt;
    logic [31:0]    r_bitlen;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_frame_err;
    logic           r_overrun_err;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_cts;

    logic [31:0]    w_bitlen_in;
    logic           w_full;
    logic           w_pop;
    logic           w_stop_hit;
    logic           w_push;
    logic [CW-1:0]  w_count_next;

    // txd is asynchronous; the synchroniser idles high so reset never looks like a start bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= txd;
            r_rxs   <= r_sync1;
        end
    end

    assign w_bitlen_in  = (dbr < 32'd4) ? 32'd4 : dbr;
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_pop        = rx_ready && (r_count != '0);
    assign w_stop_hit   = (r_state == S_STOP) && (r_cnt == 32'd0);
    // a full FIFO still accepts the byte if the head is leaving in the same cycle
    assign w_push       = w_stop_hit && r_rxs && (!w_full || w_pop);
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 32'd0;
            r_bitlen      <= 32'd4;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_bitlen <= w_bitlen_in;
                        r_cnt    <= (w_bitlen_in >> 1) - 32'd1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == 32'd0) begin
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt     <= r_bitlen - 32'd1;
                            r_bit_idx <= 3'd0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == 32'd0) begin
                        r_shift <= {r_rxs, r_shift[7:1]};
                        r_cnt   <= r_bitlen - 32'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == 32'd0) begin
                        if (r_rxs) begin
                            r_overrun_err <= !w_push;
                            r_state       <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_BREAK: begin
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cts    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_cts   <= (w_count_next <= CW'(FIFO_DEPTH - CTS_MARGIN));
        end
    end

    // head byte is read straight from the array; forced to zero while empty
    assign rx_data     = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_valid    = (r_count != '0);
    assign fifo_count  = r_count;
    assign cts         = r_cts;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_dce_uart_rx.sv
// Bench for dce_uart_rx: a queue-based model predicts each character's arrival from the
// bit-timing rules and is compared against the DUT every cycle, plus literal spot checks.
module tb_dce_uart_rx;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        txd;
    logic [31:0] dbr;
    logic        rx_ready;
    logic        cts;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun_err;
    logic [3:0]  fifo_count;

    dce_uart_rx #(.FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .txd         (txd),
        .dbr         (dbr),
        .cts         (cts),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .fifo_count  (fifo_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // pending characters: clock edge of the stop sample, byte, stop bit level
    int         sched_edge [$];
    logic [7:0] sched_byte [$];
    bit         sched_good [$];

    logic [7:0] mq [$];
    bit m_cts   = 1'b0;
    bit m_frame = 1'b0;
    bit m_ovr   = 1'b0;

    int last_e0;
    int last_push;
    int rise_cyc    = -1;
    bit prev_valid  = 1'b0;
    int n_acc       = 0;
    int ovr_pulses  = 0;
    int frm_pulses  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // reference model, advanced once per clock edge
    always @(posedge clock) begin
        int pre;
        bit pop;
        cyc     = cyc + 1;
        m_frame = 1'b0;
        m_ovr   = 1'b0;
        if (!reset_n) begin
            mq.delete();
            sched_edge.delete();
            sched_byte.delete();
            sched_good.delete();
            m_cts = 1'b0;
        end else begin
            pre = mq.size();
            pop = rx_ready && (pre > 0);
            if (pop) void'(mq.pop_front());
            if (sched_edge.size() > 0 && sched_edge[0] == cyc) begin
                if (sched_good[0]) begin
                    if (pre < DEPTH || pop) mq.push_back(sched_byte[0]);
                    else m_ovr = 1'b1;
                end else begin
                    m_frame = 1'b1;
                end
                void'(sched_edge.pop_front());
                void'(sched_byte.pop_front());
                void'(sched_good.pop_front());
            end
            m_cts = (mq.size() <= DEPTH - MARGIN);
        end
    end

    always @(posedge clock) begin
        if (reset_n && rx_valid && rx_ready) begin
            n_acc++;
            $display("rx byte %02h accepted", rx_data);
        end
    end

    // per-cycle comparison against the model
    always @(negedge clock) begin
        if (!reset_n) begin
            check("rst_cts", 32'(cts), 32'd0);
            check("rst_valid", 32'(rx_valid), 32'd0);
            check("rst_data", 32'(rx_data), 32'd0);
            check("rst_count", 32'(fifo_count), 32'd0);
            check("rst_frame", 32'(frame_err), 32'd0);
            check("rst_ovr", 32'(overrun_err), 32'd0);
        end else begin
            check("valid", 32'(rx_valid), 32'(mq.size() != 0));
            check("count", 32'(fifo_count), 32'(mq.size()));
            check("cts", 32'(cts), 32'(m_cts));
            check("frame_err", 32'(frame_err), 32'(m_frame));
            check("overrun_err", 32'(overrun_err), 32'(m_ovr));
            if (mq.size() != 0) check("data", 32'(rx_data), 32'(mq[0]));
        end
        if (rx_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (overrun_err) ovr_pulses++;
        if (frame_err) frm_pulses++;
    end

    // one 8N1 character; stop bit lasts bl-1 edges so a following call is exactly back-to-back
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int bl);
        int blen;
        int half;
        blen = (bl < 4) ? 4 : bl;
        half = blen >> 1;
        dbr  = 32'(bl);
        @(posedge clock);
        #1;
        txd       = 1'b0;
        last_e0   = cyc;
        last_push = cyc + 3 + half + 9 * blen;
        sched_edge.push_back(last_push);
        sched_byte.push_back(b);
        sched_good.push_back(stop_val);
        for (int i = 0; i < 8; i++) begin
            repeat (bl) @(posedge clock);
            #1;
            txd = b[i];
        end
        repeat (bl) @(posedge clock);
        #1;
        txd = stop_val;
        repeat (bl - 1) @(posedge clock);
    endtask

    initial begin
        logic [7:0] b2b [20];
        int target;
        reset_n  = 1'b0;
        txd      = 1'b1;
        dbr      = 32'd16;
        rx_ready = 1'b0;

        // reset and cts release
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("reset_cts_low", 32'(cts), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("cts_after_reset", 32'(cts), 32'd1);

        // single byte with latency pin
        rise_cyc = -1;
        send_byte(8'h55, 1'b1, 16);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("single_latency", 32'(rise_cyc), 32'(last_e0 + 155));
        check("single_data", 32'(rx_data), 32'h55);
        check("single_count", 32'(fifo_count), 32'd1);
        @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
        @(negedge clock);
        check("single_popped", 32'(rx_valid), 32'd0);

        // back-to-back, no backpressure
        n_acc    = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) b2b[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 20; i++) send_byte(b2b[i], 1'b1, 10);
        repeat (150) @(posedge clock);
        @(negedge clock);
        check("b2b_received", 32'(n_acc), 32'd20);
        check("b2b_empty", 32'(fifo_count), 32'd0);

        // flow control and overrun
        rx_ready   = 1'b0;
        ovr_pulses = 0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b1, 16);
        @(negedge clock);
        check("flow_count6", 32'(fifo_count), 32'd6);
        check("flow_cts6", 32'(cts), 32'd1);
        send_byte(8'h16, 1'b1, 16);
        @(negedge clock);
        check("flow_count7", 32'(fifo_count), 32'd7);
        check("flow_cts7", 32'(cts), 32'd0);
        send_byte(8'h17, 1'b1, 16);
        send_byte(8'h99, 1'b1, 16);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("ovr_pulses", 32'(ovr_pulses), 32'd1);
        check("ovr_count", 32'(fifo_count), 32'd8);
        check("ovr_head", 32'(rx_data), 32'h10);

        // push and pop at the same stop sample while full
        fork
            send_byte(8'hAB, 1'b1, 16);
            begin
                repeat (3) @(posedge clock);
                #1;
                while (cyc < last_push - 1) begin
                    @(posedge clock);
                    #1;
                end
                rx_ready = 1'b1;
                @(posedge clock);
                #1 rx_ready = 1'b0;
            end
        join
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("pp_ovr_pulses", 32'(ovr_pulses), 32'd1);
        check("pp_count", 32'(fifo_count), 32'd8);
        check("pp_head", 32'(rx_data), 32'h11);
        @(posedge clock);
        #1 rx_ready = 1'b1;
        repeat (20) @(posedge clock);
        #1 rx_ready = 1'b0;
        @(negedge clock);
        check("pp_drained", 32'(fifo_count), 32'd0);

        // framing error and break
        frm_pulses = 0;
        send_byte(8'hA3, 1'b0, 16);
        repeat (40 * 16) @(posedge clock);
        #1 txd = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("frm_pulses", 32'(frm_pulses), 32'd1);
        check("frm_nopush", 32'(fifo_count), 32'd0);
        send_byte(8'h0F, 1'b1, 16);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("after_break_data", 32'(rx_data), 32'h0F);
        check("after_break_frm", 32'(frm_pulses), 32'd1);

        // glitch rejection with one byte already buffered
        send_byte(8'h77, 1'b1, 16);
        repeat (20) @(posedge clock);
        #1 txd = 1'b0;
        repeat (6) @(posedge clock);
        #1 txd = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("glitch_count", 32'(fifo_count), 32'd2);

        // reset during data bit 4
        fork
            send_byte(8'h3C, 1'b1, 16);
            begin
                repeat (3) @(posedge clock);
                #1;
                target = last_push - 5 * 16 + 2;
                while (cyc < target) begin
                    @(posedge clock);
                    #1;
                end
                reset_n = 1'b0;
            end
        join
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_cts", 32'(cts), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_cts_rise", 32'(cts), 32'd1);
        repeat (10) @(posedge clock);
        send_byte(8'hC3, 1'b1, 16);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("post_rst_data", 32'(rx_data), 32'hC3);
        check("post_rst_count", 32'(fifo_count), 32'd1);

        repeat (5) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
